// File: rtl/ras_multi_lane.sv
// Return-address stack fed by a multi-lane fetch bundle: at most one push/pop/swap per
// cycle, taken from the lowest active lane, with checkpoint restore on misprediction.
module ras_multi_lane #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LANES      = 5,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 valid_i,
  input  logic [LANES-1:0]                     call_i,
  input  logic [LANES-1:0]                     return_i,
  input  logic [LANES*ADDR_WIDTH-1:0]          ret_addr_i,
  input  logic                                 restore_en_i,
  input  logic [$clog2(DEPTH)-1:0]             restore_tos_i,
  input  logic [$clog2(DEPTH):0]               restore_count_i,
  output logic                                 pred_valid_o,
  output logic [ADDR_WIDTH-1:0]                pred_target_o,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] pred_lane_o,
  output logic [$clog2(DEPTH)-1:0]             tos_checkpoint_o,
  output logic [$clog2(DEPTH):0]               count_checkpoint_o,
  output logic                                 overflow_o,
  output logic                                 underflow_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [ADDR_WIDTH-1:0] entry_q [DEPTH];
  logic [PTR_W-1:0]      tos_q, tos_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  ev_found, ev_call, ev_ret;
  logic [LANE_W-1:0]     ev_lane;
  logic [ADDR_WIDTH-1:0] ev_addr;

  logic                  wr_en;
  logic [PTR_W-1:0]      wr_idx;
  logic                  cnt_zero, cnt_full;

  assign cnt_zero = (cnt_q == '0);
  assign cnt_full = (cnt_q == CNT_W'(DEPTH));

  assign tos_checkpoint_o   = tos_q;
  assign count_checkpoint_o = cnt_q;

  // Priority pick: scanning high to low leaves the lowest active lane as the winner.
  always_comb begin
    ev_found = 1'b0;
    ev_call  = 1'b0;
    ev_ret   = 1'b0;
    ev_lane  = '0;
    ev_addr  = '0;
    for (int k = int'(LANES) - 1; k >= 0; k--) begin
      if (valid_i && (call_i[k] || return_i[k])) begin
        ev_found = 1'b1;
        ev_call  = call_i[k];
        ev_ret   = return_i[k];
        ev_lane  = LANE_W'(k);
        ev_addr  = ret_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Next-state and same-cycle prediction/pulse outputs.
  always_comb begin
    tos_d         = tos_q;
    cnt_d         = cnt_q;
    wr_en         = 1'b0;
    wr_idx        = tos_q;
    pred_valid_o  = 1'b0;
    pred_target_o = '0;
    pred_lane_o   = '0;
    overflow_o    = 1'b0;
    underflow_o   = 1'b0;

    if (restore_en_i) begin
      tos_d = restore_tos_i;
      cnt_d = (restore_count_i > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : restore_count_i;
    end else if (ev_found) begin
      if (ev_ret && !cnt_zero) begin
        pred_valid_o  = 1'b1;
        pred_target_o = entry_q[tos_q];
        pred_lane_o   = ev_lane;
      end
      if (ev_call && ev_ret && !cnt_zero) begin
        wr_en = 1'b1;
      end else if (ev_call) begin
        // A swap on an empty stack degrades to a push but still flags the missing pop.
        tos_d       = tos_q + PTR_W'(1);
        wr_idx      = tos_q + PTR_W'(1);
        wr_en       = 1'b1;
        underflow_o = ev_ret;
        if (cnt_full) overflow_o = 1'b1;
        else          cnt_d      = cnt_q + CNT_W'(1);
      end else if (!cnt_zero) begin
        tos_d = tos_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        underflow_o = 1'b1;
      end
    end

    if (!reset) begin
      pred_valid_o  = 1'b0;
      pred_target_o = '0;
      pred_lane_o   = '0;
      overflow_o    = 1'b0;
      underflow_o   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tos_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      if (wr_en) entry_q[wr_idx] <= ev_addr;
    end
  end

endmodule

// File: tb/tb_ras_multi_lane.sv
// Directed bench for ras_multi_lane: each driven cycle queues its hand-computed
// expected outputs; a negedge monitor pops and compares.
module tb_ras_multi_lane;

  localparam int unsigned AW = 32;
  localparam int unsigned NL = 5;
  localparam int unsigned DP = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_i;
  logic [NL-1:0]    call_i, return_i;
  logic [NL*AW-1:0] ret_addr_i;
  logic             restore_en_i;
  logic [2:0]       restore_tos_i;
  logic [3:0]       restore_count_i;
  logic             pred_valid_o;
  logic [AW-1:0]    pred_target_o;
  logic [2:0]       pred_lane_o;
  logic [2:0]       tos_checkpoint_o;
  logic [3:0]       count_checkpoint_o;
  logic             overflow_o, underflow_o;

  typedef struct {
    logic        pv;
    logic [31:0] tgt;
    logic [2:0]  lane;
    logic        ovf;
    logic        unf;
    logic [2:0]  tos;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  ras_multi_lane #(.ADDR_WIDTH(AW), .LANES(NL), .DEPTH(DP)) dut (
    .clk                (clk),
    .reset              (reset),
    .valid_i            (valid_i),
    .call_i             (call_i),
    .return_i           (return_i),
    .ret_addr_i         (ret_addr_i),
    .restore_en_i       (restore_en_i),
    .restore_tos_i      (restore_tos_i),
    .restore_count_i    (restore_count_i),
    .pred_valid_o       (pred_valid_o),
    .pred_target_o      (pred_target_o),
    .pred_lane_o        (pred_lane_o),
    .tos_checkpoint_o   (tos_checkpoint_o),
    .count_checkpoint_o (count_checkpoint_o),
    .overflow_o         (overflow_o),
    .underflow_o        (underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("pred_valid", 32'(pred_valid_o),       32'(mon_e.pv));
      chk("pred_target", pred_target_o,           mon_e.tgt);
      chk("pred_lane",  32'(pred_lane_o),        32'(mon_e.lane));
      chk("overflow",   32'(overflow_o),         32'(mon_e.ovf));
      chk("underflow",  32'(underflow_o),        32'(mon_e.unf));
      chk("tos_ckpt",   32'(tos_checkpoint_o),   32'(mon_e.tos));
      chk("count_ckpt", 32'(count_checkpoint_o), 32'(mon_e.cnt));
    end else if (pred_valid_o || overflow_o || underflow_o) begin
      checks++;
      errors++;
      $display("FAIL unexpected_output: pv=%0b ovf=%0b unf=%0b with nothing expected at %0t",
               pred_valid_o, overflow_o, underflow_o, $time);
    end
  end

  // Drive one cycle (called just after a rising edge); lane al carries address a,
  // every other lane carries a recognisable junk address.
  task automatic step(input logic v, input logic [4:0] c, input logic [4:0] r,
                      input int al, input logic [31:0] a,
                      input logic ren, input logic [2:0] rt, input logic [3:0] rc,
                      input logic epv, input logic [31:0] et, input logic [2:0] el,
                      input logic eo, input logic eu,
                      input logic [2:0] etos, input logic [3:0] ecnt,
                      input logic rst_mid);
    exp_t e;
    valid_i = v;
    call_i = c;
    return_i = r;
    for (int k = 0; k < int'(NL); k++)
      ret_addr_i[k*AW +: AW] = (k == al) ? a : (32'hBAD0_0000 + 32'(k));
    restore_en_i = ren;
    restore_tos_i = rt;
    restore_count_i = rc;
    e.pv = epv; e.tgt = et; e.lane = el; e.ovf = eo; e.unf = eu;
    e.tos = etos; e.cnt = ecnt;
    exp_q.push_back(e);
    if (rst_mid) begin
      #1 reset = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int lane, input logic [31:0] a, input logic eo,
                      input logic [2:0] etos, input logic [3:0] ecnt);
    logic [4:0] m;
    m = '0;
    m[lane] = 1'b1;
    step(1'b1, m, 5'b0, lane, a, 1'b0, 3'd0, 4'd0,
         1'b0, 32'h0, 3'd0, eo, 1'b0, etos, ecnt, 1'b0);
  endtask

  task automatic pop(input int lane, input logic epv, input logic [31:0] et, input logic eu,
                     input logic [2:0] etos, input logic [3:0] ecnt);
    logic [4:0] m;
    m = '0;
    m[lane] = 1'b1;
    step(1'b1, 5'b0, m, lane, 32'h0, 1'b0, 3'd0, 4'd0,
         epv, et, epv ? 3'(lane) : 3'd0, 1'b0, eu, etos, ecnt, 1'b0);
  endtask

  task automatic idle(input logic [2:0] etos, input logic [3:0] ecnt);
    step(1'b0, 5'b0, 5'b0, 0, 32'h0, 1'b0, 3'd0, 4'd0,
         1'b0, 32'h0, 3'd0, 1'b0, 1'b0, etos, ecnt, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    valid_i = 1'b0;
    call_i = '0;
    return_i = '0;
    ret_addr_i = '0;
    restore_en_i = 1'b0;
    restore_tos_i = '0;
    restore_count_i = '0;
    @(posedge clk);
    #1;

    // Held in reset: outputs stay 0 and the push is discarded.
    pop(0, 1'b0, 32'h0, 1'b0, 3'd0, 4'd0);
    push(0, 32'hEE, 1'b0, 3'd0, 4'd0);
    reset = 1'b1;
    idle(3'd0, 4'd0);

    // Call then return on a later lane.
    push(0, 32'h104, 1'b0, 3'd0, 4'd0);
    pop(2, 1'b1, 32'h104, 1'b0, 3'd1, 4'd1);
    idle(3'd0, 4'd0);

    // Lane 2 call wins over lane 4 call+return.
    step(1'b1, 5'b10100, 5'b10000, 2, 32'h200, 1'b0, 3'd0, 4'd0,
         1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);
    pop(0, 1'b1, 32'h200, 1'b0, 3'd1, 4'd1);

    // Fill past depth, then drain past empty.
    for (int i = 0; i < 9; i++)
      push(0, 32'h10 + 32'(i), (i == 8), 3'(i % 8), 4'((i < 8) ? i : 8));
    for (int j = 0; j < 8; j++)
      pop(1, 1'b1, 32'h18 - 32'(j), 1'b0, 3'((9 - j) % 8), 4'(8 - j));
    pop(1, 1'b0, 32'h0, 1'b1, 3'd1, 4'd0);

    // Checkpoint at (3,3), push twice, restore while a return is presented.
    step(1'b0, 5'b0, 5'b0, 0, 32'h0, 1'b1, 3'd0, 4'd0,
         1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 3'd1, 4'd0, 1'b0);
    push(0, 32'hA0, 1'b0, 3'd0, 4'd0);
    push(0, 32'hA1, 1'b0, 3'd1, 4'd1);
    push(0, 32'hA2, 1'b0, 3'd2, 4'd2);
    idle(3'd3, 4'd3);
    push(0, 32'hB0, 1'b0, 3'd3, 4'd3);
    push(0, 32'hB1, 1'b0, 3'd4, 4'd4);
    step(1'b1, 5'b0, 5'b00001, 0, 32'h0, 1'b1, 3'd3, 4'd3,
         1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 3'd5, 4'd5, 1'b0);
    pop(0, 1'b1, 32'hA2, 1'b0, 3'd3, 4'd3);

    // Coroutine swap on a non-empty stack.
    push(0, 32'h300, 1'b0, 3'd2, 4'd2);
    step(1'b1, 5'b00010, 5'b00010, 1, 32'h400, 1'b0, 3'd0, 4'd0,
         1'b1, 32'h300, 3'd1, 1'b0, 1'b0, 3'd3, 4'd3, 1'b0);
    pop(0, 1'b1, 32'h400, 1'b0, 3'd3, 4'd3);

    // Restore count saturates at DEPTH.
    step(1'b0, 5'b0, 5'b0, 0, 32'h0, 1'b1, 3'd5, 4'd15,
         1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 3'd2, 4'd2, 1'b0);
    idle(3'd5, 4'd8);

    // Coroutine on an empty stack behaves as push plus underflow.
    step(1'b0, 5'b0, 5'b0, 0, 32'h0, 1'b1, 3'd6, 4'd0,
         1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 3'd5, 4'd8, 1'b0);
    step(1'b1, 5'b01000, 5'b01000, 3, 32'h500, 1'b0, 3'd0, 4'd0,
         1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 3'd6, 4'd0, 1'b0);
    pop(3, 1'b1, 32'h500, 1'b0, 3'd7, 4'd1);

    // valid_i low holds state.
    step(1'b0, 5'b00001, 5'b0, 0, 32'h77, 1'b0, 3'd0, 4'd0,
         1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 3'd6, 4'd0, 1'b0);
    idle(3'd6, 4'd0);

    // Async reset mid-cycle during a push.
    push(0, 32'hC0, 1'b0, 3'd6, 4'd0);
    push(0, 32'hC1, 1'b0, 3'd7, 4'd1);
    push(0, 32'hC2, 1'b0, 3'd0, 4'd2);
    step(1'b1, 5'b00001, 5'b0, 0, 32'hC3, 1'b0, 3'd0, 4'd0,
         1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
    reset = 1'b1;
    pop(0, 1'b0, 32'h0, 1'b1, 3'd0, 4'd0);
    push(4, 32'hD0, 1'b0, 3'd0, 4'd0);
    pop(4, 1'b1, 32'hD0, 1'b0, 3'd1, 4'd1);
    idle(3'd0, 4'd0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
